// File: rtl/pmem_arb_pkg.sv
// Shared types and default widths for the physical-memory port arbiter.
package pmem_arb_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 32;
  localparam int unsigned DEFAULT_LINE_W = 256;

  typedef enum logic [1:0] {
    StIdle,
    StBusyI,
    StBusyD,
    StRecover
  } arb_state_t;

  typedef enum logic {
    ReqI,
    ReqD
  } req_id_t;

endpackage

// File: rtl/pmem_arb_grant.sv
// Combinational requester selector. With PMEM_ARB_RR_EN defined a tie goes to the favoured
// requester; otherwise the dcache always wins a tie.
module pmem_arb_grant
  import pmem_arb_pkg::*;
(
  input  logic    i_req_i,
  input  logic    d_req_i,
  input  req_id_t favour_i,
  output logic    grant_valid_o,
  output req_id_t grant_id_o
);

  req_id_t tie_pick;

`ifdef PMEM_ARB_RR_EN
  assign tie_pick = favour_i;
`else
  logic unused_favour;
  assign unused_favour = favour_i;
  assign tie_pick      = ReqD;
`endif

  always_comb begin
    grant_valid_o = i_req_i | d_req_i;
    grant_id_o    = ReqI;
    if (i_req_i && d_req_i) begin
      grant_id_o = tie_pick;
    end else if (d_req_i) begin
      grant_id_o = ReqD;
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single cacheline adaptor port between icache and dcache, one line at a time.
// Define PMEM_ARB_RR_EN for round-robin tie breaking; default is fixed dcache priority.
module pmem_arbiter
  import pmem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DEFAULT_ADDR_W,
  parameter int unsigned LINE_W = DEFAULT_LINE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              m_read,
  output logic              m_write,
  output logic [ADDR_W-1:0] m_addr,
  output logic [LINE_W-1:0] m_wdata,
  input  logic [LINE_W-1:0] m_rdata,
  input  logic              m_resp
);

  arb_state_t        state_q, state_d;
  logic              m_read_q, m_read_d;
  logic              m_write_q, m_write_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [LINE_W-1:0] m_wdata_q, m_wdata_d;

  logic    d_req;
  logic    grant_valid;
  req_id_t grant_id;
  req_id_t favour;

  assign d_req = d_read | d_write;

`ifdef PMEM_ARB_RR_EN
  req_id_t rr_q, rr_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= ReqI;
    end else begin
      rr_q <= rr_d;
    end
  end

  assign favour = rr_q;
`else
  assign favour = ReqD;
`endif

  pmem_arb_grant u_grant (
    .i_req_i       (i_read),
    .d_req_i       (d_req),
    .favour_i      (favour),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  always_comb begin
    state_d   = state_q;
    m_read_d  = m_read_q;
    m_write_d = m_write_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
`ifdef PMEM_ARB_RR_EN
    rr_d      = rr_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          if (grant_id == ReqD) begin
            state_d   = StBusyD;
            m_addr_d  = d_addr;
            m_wdata_d = d_wdata;
            // A read+write protocol error is served as a writeback.
            m_write_d = d_write;
            m_read_d  = ~d_write;
          end else begin
            state_d   = StBusyI;
            m_addr_d  = i_addr;
            m_read_d  = 1'b1;
            m_write_d = 1'b0;
          end
`ifdef PMEM_ARB_RR_EN
          rr_d = (grant_id == ReqD) ? ReqI : ReqD;
`endif
        end
      end
      StBusyI, StBusyD: begin
        if (m_resp) begin
          m_read_d  = 1'b0;
          m_write_d = 1'b0;
          state_d   = StRecover;
        end
      end
      StRecover: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      m_read_q  <= 1'b0;
      m_write_q <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
    end else begin
      state_q   <= state_d;
      m_read_q  <= m_read_d;
      m_write_q <= m_write_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
    end
  end

  assign m_read  = m_read_q;
  assign m_write = m_write_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;

  // Read data fans out to both caches; only the granted side sees a resp.
  assign i_rdata = m_rdata;
  assign d_rdata = m_rdata;
  assign i_resp  = (state_q == StBusyI) & m_resp;
  assign d_resp  = (state_q == StBusyD) & m_resp;

`ifndef SYNTHESIS
  a_no_read_and_write : assert property (@(posedge clk) disable iff (!reset_n)
    !(d_read && d_write))
    else $error("pmem_arbiter: d_read and d_write asserted together");
`endif

endmodule

// File: tb/tb_pmem_arbiter.sv
// Scoreboard bench for pmem_arbiter: expected transactions are queued in grant order and
// matched against downstream commands and responses by a monitor.
module tb_pmem_arbiter;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned LINE_W  = 256;
  localparam int unsigned RespLat = 8;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    bit                wr;
    bit                is_d;
    logic [LINE_W-1:0] wdata;
  } item_t;

  logic              clk;
  logic              reset_n;
  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              m_read;
  logic              m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [LINE_W-1:0] m_rdata;
  logic              m_resp;

  int    checks_n;
  int    errors_n;
  item_t exp_q[$];
  item_t act;
  bit    act_valid;
  bit    prev_cmd;
  int    post_resp;
  bit    spur_req;
  int    lat_cnt;

  pmem_arbiter #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_read  (i_read),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_resp  (i_resp),
    .d_read  (d_read),
    .d_write (d_write),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_resp  (d_resp),
    .m_read  (m_read),
    .m_write (m_write),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_resp  (m_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] obs,
                          input logic [LINE_W-1:0] exp);
    checks_n++;
    if (obs !== exp) begin
      errors_n++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] line_for(input logic [ADDR_W-1:0] addr);
    if (addr == 32'h0000_1040) return {32{8'hA5}};
    return {8{addr ^ 32'hC0DE_0000}};
  endfunction

  function automatic item_t mk(input logic [ADDR_W-1:0] addr, input bit wr, input bit is_d,
                               input logic [LINE_W-1:0] wdata);
    item_t it;
    it.addr  = addr;
    it.wr    = wr;
    it.is_d  = is_d;
    it.wdata = wdata;
    return it;
  endfunction

  // Adaptor model: responds RespLat cycles into a command, or once on a stray-pulse request.
  initial begin
    m_resp  = 1'b0;
    m_rdata = '0;
    lat_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (m_resp) begin
        m_resp = 1'b0;
      end else if (spur_req) begin
        m_resp   = 1'b1;
        m_rdata  = '1;
        spur_req = 1'b0;
      end else if (reset_n && (m_read || m_write)) begin
        lat_cnt++;
        if (lat_cnt == RespLat) begin
          m_resp  = 1'b1;
          m_rdata = line_for(m_addr);
          lat_cnt = 0;
        end
      end else begin
        lat_cnt = 0;
      end
    end
  end

  // Monitor: match command starts and responses against the expected queue.
  always @(negedge clk) begin
    if (!reset_n) begin
      act_valid = 1'b0;
      prev_cmd  = 1'b0;
      post_resp = 0;
    end else begin
      if (post_resp != 0) begin
        check_eq("cmd_low_after_resp", {m_read, m_write}, 2'b00);
        post_resp--;
      end
      if ((m_read || m_write) && !prev_cmd) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_cmd", 1, 0);
        end else begin
          act       = exp_q.pop_front();
          act_valid = 1'b1;
          check_eq("m_addr", m_addr, act.addr);
          check_eq("m_write", m_write, act.wr);
          check_eq("m_read", m_read, !act.wr);
          if (act.wr) check_eq("m_wdata", m_wdata, act.wdata);
        end
      end
      if (m_resp) begin
        if (act_valid) begin
          check_eq("i_resp", i_resp, !act.is_d);
          check_eq("d_resp", d_resp, act.is_d);
          if (!act.wr && act.is_d) check_eq("d_rdata", d_rdata, line_for(act.addr));
          if (!act.is_d) check_eq("i_rdata", i_rdata, line_for(act.addr));
          act_valid = 1'b0;
          post_resp = 2;
        end else begin
          check_eq("stray_resp", {i_resp, d_resp}, 2'b00);
        end
      end else if (i_resp || d_resp) begin
        check_eq("resp_without_m_resp", {i_resp, d_resp}, 2'b00);
      end
      prev_cmd = m_read || m_write;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Waits for the next cache resp, then steps into the following (RECOVER) cycle.
  task automatic wait_resp(output bit got_i, output bit got_d);
    got_i = 1'b0;
    got_d = 1'b0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (i_resp || d_resp) begin
        got_i = i_resp;
        got_d = d_resp;
        break;
      end
    end
    if (!got_i && !got_d) check_eq("resp_timeout", 0, 1);
    cycle();
  endtask

  initial begin
    bit gi, gd;
    int ni, nd;
    logic [LINE_W-1:0] wb_line;

    checks_n = 0;
    errors_n = 0;
    spur_req = 1'b0;
    reset_n  = 1'b0;
    i_read   = 1'b0;
    i_addr   = '0;
    d_read   = 1'b0;
    d_write  = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    repeat (2) cycle();
    check_eq("rst_m_read", m_read, 0);
    check_eq("rst_m_write", m_write, 0);
    check_eq("rst_m_addr", m_addr, 0);
    check_eq("rst_m_wdata", m_wdata, 0);
    check_eq("rst_resp", {i_resp, d_resp}, 2'b00);
    reset_n = 1'b1;
    cycle();

    // Lone icache read
    i_addr = 32'h0000_1040;
    i_read = 1'b1;
    exp_q.push_back(mk(32'h0000_1040, 1'b0, 1'b0, '0));
    check_eq("no_cmd_before_grant", m_read, 0);
    cycle();
    check_eq("i_grant_latency", m_read, 1);
    wait_resp(gi, gd);
    check_eq("lone_i_who", {gi, gd}, 2'b10);
    i_read = 1'b0;

    // Dcache writeback
    repeat (2) cycle();
    wb_line = {2{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};
    d_addr  = 32'h0000_2000;
    d_wdata = wb_line;
    d_write = 1'b1;
    exp_q.push_back(mk(32'h0000_2000, 1'b1, 1'b1, wb_line));
    wait_resp(gi, gd);
    check_eq("wb_who", {gi, gd}, 2'b01);
    d_write = 1'b0;
    d_wdata = '0;
    check_eq("wb_recover_write", m_write, 0);
    cycle();
    check_eq("wb_idle_write", m_write, 0);
    cycle();

`ifdef PMEM_ARB_RR_EN
    // Both held: alternating service starting with icache
    i_addr = 32'h0000_5000;
    d_addr = 32'h0000_6000;
    i_read = 1'b1;
    d_read = 1'b1;
    exp_q.push_back(mk(32'h0000_5000, 1'b0, 1'b0, '0));
    exp_q.push_back(mk(32'h0000_6000, 1'b0, 1'b1, '0));
    exp_q.push_back(mk(32'h0000_5040, 1'b0, 1'b0, '0));
    exp_q.push_back(mk(32'h0000_6040, 1'b0, 1'b1, '0));
    ni = 0;
    nd = 0;
    for (int k = 0; k < 4; k++) begin
      wait_resp(gi, gd);
      check_eq("rr_order", gd, (k % 2) != 0);
      if (gi) begin
        ni++;
        i_addr = 32'h0000_5040;
        if (ni == 2) i_read = 1'b0;
      end
      if (gd) begin
        nd++;
        d_addr = 32'h0000_6040;
        if (nd == 2) d_read = 1'b0;
      end
    end
`else
    // Simultaneous: dcache first, icache right after the recovery gap
    i_addr = 32'h0000_3000;
    d_addr = 32'h0000_4000;
    i_read = 1'b1;
    d_read = 1'b1;
    exp_q.push_back(mk(32'h0000_4000, 1'b0, 1'b1, '0));
    exp_q.push_back(mk(32'h0000_3000, 1'b0, 1'b0, '0));
    wait_resp(gi, gd);
    check_eq("prio_d_first", {gi, gd}, 2'b01);
    d_read = 1'b0;
    cycle();
    check_eq("prio_idle_gap", m_read, 0);
    cycle();
    check_eq("prio_i_after_recover", m_read, 1);
    wait_resp(gi, gd);
    check_eq("prio_i_second", {gi, gd}, 2'b10);
    i_read = 1'b0;
`endif
    repeat (2) cycle();

    // Held request through RECOVER yields exactly one extra transaction
    i_addr = 32'h0000_7000;
    i_read = 1'b1;
    exp_q.push_back(mk(32'h0000_7000, 1'b0, 1'b0, '0));
    exp_q.push_back(mk(32'h0000_7000, 1'b0, 1'b0, '0));
    wait_resp(gi, gd);
    check_eq("held_recover_m_read", m_read, 0);
    wait_resp(gi, gd);
    check_eq("held_second_who", {gi, gd}, 2'b10);
    i_read = 1'b0;
    repeat (4) cycle();
    check_eq("held_queue_drained", exp_q.size(), 0);

    // Stray m_resp while idle
    spur_req = 1'b1;
    repeat (4) cycle();
    check_eq("stray_no_cmd", {m_read, m_write}, 2'b00);

    // Asynchronous reset during BUSY_D
    d_addr = 32'h0000_8000;
    d_read = 1'b1;
    exp_q.push_back(mk(32'h0000_8000, 1'b0, 1'b1, '0));
    repeat (3) cycle();
    check_eq("busy_d_m_read", m_read, 1);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("async_rst_m_read", m_read, 0);
    check_eq("async_rst_m_write", m_write, 0);
    check_eq("async_rst_d_resp", d_resp, 0);
    d_read = 1'b0;
    cycle();
    reset_n = 1'b1;
    cycle();
    check_eq("post_rst_idle", m_read, 0);
    d_addr = 32'h0000_8040;
    d_read = 1'b1;
    exp_q.push_back(mk(32'h0000_8040, 1'b0, 1'b1, '0));
    cycle();
    check_eq("post_rst_grant", m_read, 1);
    wait_resp(gi, gd);
    check_eq("post_rst_who", {gi, gd}, 2'b01);
    d_read = 1'b0;
    repeat (3) cycle();

    check_eq("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_n, errors_n);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
